// File: rtl/reg_resp_pkg.sv
// Shared types and helpers for the register-bus responder.
// Default request/response structs are sized for AW = DW = 32.
package reg_resp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } reg_resp_state_e;

    localparam int unsigned LockBit = 0;
    localparam int unsigned DefAW   = 32;
    localparam int unsigned DefDW   = 32;

    typedef struct packed {
        logic [DefAW-1:0]   addr;
        logic               write;
        logic [DefDW-1:0]   wdata;
        logic [DefDW/8-1:0] wstrb;
        logic               valid;
    } reg_resp_req_t;

    typedef struct packed {
        logic [DefDW-1:0] rdata;
        logic             error;
        logic             ready;
    } reg_resp_rsp_t;

    // Misaligned or out-of-range; the address is checked untruncated (AW <= 64).
    function automatic logic reg_resp_err(input logic [63:0] addr,
                                          input int unsigned no_regs,
                                          input int unsigned dw);
        int unsigned off_w;
        logic [63:0] mask;
        logic [63:0] idx;
        off_w = $clog2(dw / 8);
        mask  = (64'd1 << off_w) - 64'd1;
        idx   = addr >> off_w;
        return ((addr & mask) != 64'd0) || (idx >= 64'(no_regs));
    endfunction

endpackage

// File: rtl/reg_resp_wait_cnt.sv
// Wait-cycle counter: cleared on entry to WAIT, advances while enabled,
// and flags done when it reaches RspLatency-1. Only built for RspLatency > 0.
module reg_resp_wait_cnt
    import reg_resp_pkg::*;
#(
    parameter int unsigned RspLatency = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntW = (RspLatency < 1) ? 1 : $clog2(RspLatency + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CntW'(RspLatency - 1));

endmodule

// File: rtl/reg_resp_regfile.sv
// Register-bus responder with NoRegs RW registers and programmable response latency.
// Optional write lock on the last register when REG_RESP_LOCK_EN is defined.
module reg_resp_regfile
    import reg_resp_pkg::*;
#(
    parameter int unsigned NoRegs     = 8,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned RspLatency = 1,
    parameter type         req_t      = reg_resp_req_t,
    parameter type         rsp_t      = reg_resp_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  req_t                     req_i,
    output rsp_t                     rsp_o,
    output logic [NoRegs-1:0][DW-1:0] reg_o,
    output logic [NoRegs-1:0]         reg_we_o,
    output logic                     dbg_state_o
);

    // Handshake: a request is presented with valid and held stable until the
    // cycle ready is high; that cycle's rising edge commits the access.
    localparam int unsigned OffW = $clog2(DW / 8);
    localparam int unsigned NB   = DW / 8;

    reg_resp_state_e           state_q, state_d;
    logic                      cnt_clr, cnt_en, wait_done;
    logic                      ready, acc_err, locked, commit_we;
    logic [AW-1:0]             idx;
    logic [NoRegs-1:0][DW-1:0] reg_q, reg_d;
    logic [NoRegs-1:0]         we_q, we_d;

    assign idx     = AW'(req_i.addr >> OffW);
    assign acc_err = reg_resp_err(64'(req_i.addr), NoRegs, DW) || (locked && req_i.write);

    if (RspLatency > 0) begin : g_wait
        reg_resp_wait_cnt #(.RspLatency(RspLatency)) u_wait_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (cnt_clr),
            .en_i   (cnt_en),
            .done_o (wait_done)
        );
    end else begin : g_no_wait
        logic unused_cnt_ctrl;
        assign unused_cnt_ctrl = cnt_clr ^ cnt_en;
        assign wait_done       = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i.valid && (RspLatency > 0)) begin
                    state_d = WAIT;
                    cnt_clr = 1'b1;
                end
            end
            WAIT: begin
                // A dropped valid abandons the access silently.
                if (!req_i.valid || wait_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        if (RspLatency == 0) begin
            ready = (state_q == IDLE) && req_i.valid;
        end else begin
            ready = (state_q == WAIT) && req_i.valid && wait_done;
        end
    end

    assign commit_we = ready && req_i.write && !acc_err;

    always_comb begin
        rsp_o = '0;
        if (ready) begin
            rsp_o.ready = 1'b1;
            rsp_o.error = acc_err;
            if (!acc_err && !req_i.write) begin
                for (int i = 0; i < NoRegs; i++) begin
                    if (idx == AW'(i)) rsp_o.rdata = reg_q[i];
                end
            end
        end
    end

    always_comb begin
        reg_d = reg_q;
        we_d  = '0;
        for (int i = 0; i < NoRegs; i++) begin
            if (commit_we && (idx == AW'(i))) begin
                we_d[i] = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (req_i.wstrb[b]) reg_d[i][b*8 +: 8] = req_i.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= '0;
            we_q  <= '0;
        end else begin
            reg_q <= reg_d;
            we_q  <= we_d;
        end
    end

`ifdef REG_RESP_LOCK_EN
    // Sticky lock; it gates writes only from the access after the locking one.
    logic lock_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (commit_we && (idx == AW'(NoRegs - 1)) &&
                     req_i.wstrb[LockBit/8] && req_i.wdata[LockBit]) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    assign reg_o       = reg_q;
    assign reg_we_o    = we_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_resp_regfile.sv
// Directed bench for reg_resp_regfile: an L = 2 instance and an L = 0 instance
// share clock and reset. Lock scenario follows REG_RESP_LOCK_EN.
module tb_reg_resp_regfile;
    import reg_resp_pkg::*;

    logic clk;
    logic rst_n;
    reg_resp_req_t req2, req0;
    reg_resp_rsp_t rsp2, rsp0;
    logic [7:0][31:0] r2, r0;
    logic [7:0] we2, we0;
    logic st2, st0;

    int n_cmp = 0;
    int n_err = 0;

    reg_resp_regfile #(.NoRegs(8), .AW(32), .DW(32), .RspLatency(2),
                       .req_t(reg_resp_req_t), .rsp_t(reg_resp_rsp_t)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .rsp_o(rsp2),
        .reg_o(r2), .reg_we_o(we2), .dbg_state_o(st2)
    );

    reg_resp_regfile #(.NoRegs(8), .AW(32), .DW(32), .RspLatency(0),
                       .req_t(reg_resp_req_t), .rsp_t(reg_resp_rsp_t)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .rsp_o(rsp0),
        .reg_o(r0), .reg_we_o(we0), .dbg_state_o(st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge following c0+3.
    task automatic acc2(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input logic [7:0] exp_we);
        req2.addr  = addr;
        req2.write = wr;
        req2.wdata = wdata;
        req2.wstrb = strb;
        req2.valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k < 2) begin
                check_eq({tag, "_early_ready"}, 64'(rsp2.ready), 64'd0);
            end else begin
                check_eq({tag, "_ready"}, 64'(rsp2.ready), 64'd1);
                check_eq({tag, "_error"}, 64'(rsp2.error), 64'(exp_err));
                check_eq({tag, "_rdata"}, 64'(rsp2.rdata), 64'(exp_rd));
            end
            @(posedge clk);
            #1;
        end
        req2.valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_we"}, 64'(we2), 64'(exp_we));
        check_eq({tag, "_idle_ready"}, 64'(rsp2.ready), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req2  = '0;
        req0  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_rsp", 64'(rsp2), 64'd0);
        check_eq("rst_regs", 64'(r2 == '0 && r0 == '0), 64'd1);
        check_eq("rst_we", 64'({we2, we0}), 64'd0);
        check_eq("rst_state", 64'({st2, st0}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // L = 0: back-to-back writes, ready in the request cycle
        req0 = '{addr: 32'h00, write: 1'b1, wdata: 32'h12345678, wstrb: 4'hF, valid: 1'b1};
        @(negedge clk);
        check_eq("l0_w0_ready", 64'({rsp0.ready, rsp0.error}), 64'b10);
        @(posedge clk);
        #1;
        req0 = '{addr: 32'h08, write: 1'b1, wdata: 32'hCAFEF00D, wstrb: 4'hF, valid: 1'b1};
        @(negedge clk);
        check_eq("l0_w1_ready", 64'({rsp0.ready, rsp0.error}), 64'b10);
        check_eq("l0_w0_we", 64'(we0), 64'h01);
        check_eq("l0_w0_reg", 64'(r0[0]), 64'h12345678);
        @(posedge clk);
        #1;
        req0 = '{addr: 32'h08, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        @(negedge clk);
        check_eq("l0_w1_we", 64'(we0), 64'h04);
        check_eq("l0_w1_reg", 64'(r0[2]), 64'hCAFEF00D);
        check_eq("l0_rd_rdata", 64'({rsp0.ready, rsp0.error, rsp0.rdata}), {31'd0, 2'b10, 32'hCAFEF00D});
        @(posedge clk);
        #1;
        req0.valid = 1'b0;
        @(negedge clk);
        check_eq("l0_idle", 64'({rsp0.ready, we0}), 64'd0);
        @(posedge clk);
        #1;

        // L = 2: full, partial, read-back and error accesses
        acc2("wr_full", 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 8'h02);
        check_eq("wr_full_reg", 64'(r2[1]), 64'hDEADBEEF);
        acc2("rd_1", 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 8'h00);
        acc2("wr_part", 1'b1, 32'h04, 32'h11223344, 4'h5, 1'b0, 32'h0, 8'h02);
        check_eq("wr_part_reg", 64'(r2[1]), 64'hDE22BE44);
        acc2("wr_nostrb", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 8'h10);
        check_eq("wr_nostrb_reg", 64'(r2[4]), 64'h0);
        acc2("rd_oor", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 8'h00);
        acc2("rd_mis", 1'b0, 32'h06, 32'h0, 4'h0, 1'b1, 32'h0, 8'h00);
        acc2("wr_oor", 1'b1, 32'h8000_0004, 32'h55555555, 4'hF, 1'b1, 32'h0, 8'h00);
        acc2("wr_mis", 1'b1, 32'h05, 32'h55555555, 4'hF, 1'b1, 32'h0, 8'h00);
        check_eq("err_no_change", 64'(r2[1]), 64'hDE22BE44);
        acc2("rd_last", 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 32'h0, 8'h00);

        // Reset asserted while a write to 0x0C sits in WAIT
        req2 = '{addr: 32'h0C, write: 1'b1, wdata: 32'h87654321, wstrb: 4'hF, valid: 1'b1};
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_wait_state", 64'(st2), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state", 64'(st2), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("mid_rst_ready", 64'(rsp2.ready), 64'd0);
        end
        req2.valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_reg3", 64'(r2[3]), 64'd0);
        check_eq("mid_rst_regs", 64'(r2 == '0), 64'd1);
        @(posedge clk);
        #1;

`ifdef REG_RESP_LOCK_EN
        acc2("lock_set", 1'b1, 32'h1C, 32'h1, 4'h1, 1'b0, 32'h0, 8'h80);
        acc2("lock_wr0", 1'b1, 32'h00, 32'hAA, 4'hF, 1'b1, 32'h0, 8'h00);
        check_eq("lock_reg0", 64'(r2[0]), 64'd0);
        acc2("lock_rd0", 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 32'h0, 8'h00);
        acc2("lock_wr_lock", 1'b1, 32'h1C, 32'h0, 4'hF, 1'b1, 32'h0, 8'h00);
        check_eq("lock_reg7", 64'(r2[7]), 64'd1);
`else
        acc2("nolock_set", 1'b1, 32'h1C, 32'h1, 4'h1, 1'b0, 32'h0, 8'h80);
        acc2("nolock_wr0", 1'b1, 32'h00, 32'hAA, 4'hF, 1'b0, 32'h0, 8'h01);
        check_eq("nolock_reg0", 64'(r2[0]), 64'hAA);
        acc2("nolock_rd0", 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 32'hAA, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
